// File: rtl/inst_fetch_pair.sv
// inst_fetch_pair: fetch-side writer for the instruction buffer.
// The block keeps the fetch PC and asks the ICache for aligned instruction
// pairs, with one request outstanding at a time. It registers each response
// as one or two {inst, pc} pushes. A flush redirects the PC, and any response
// that was in flight at the time is dropped.
module inst_fetch_pair #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        buffer_full_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_addr_ok_i,
  input  logic        icache_data_ok_i,
  input  logic [31:0] icache_rdata1_i,
  input  logic [31:0] icache_rdata2_i,
  output logic [31:0] inst1_o,
  output logic [31:0] inst2_o,
  output logic [31:0] inst1_addr_o,
  output logic [31:0] inst2_addr_o,
  output logic        inst1_valid_o,
  output logic        inst2_valid_o
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_inst1;
  logic [31:0] r_inst2;
  logic [31:0] r_inst1_addr;
  logic [31:0] r_inst2_addr;
  logic        r_valid1;
  logic        r_valid2;

  logic        w_req;
  logic        w_handshake;
  logic        w_push;
  logic        w_unused_flush_pc_lo;

  // The low bits of the redirect target are ignored because fetch is word aligned.
  assign w_unused_flush_pc_lo = ^flush_pc[1:0];

  assign w_handshake = w_req & icache_addr_ok_i;
  assign w_push      = (r_state == S_WAIT) & icache_data_ok_i & ~flush;

  // State register.
  // NOTE: the reset is synchronous, so it sits inside the clocked block and is tested first.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_REQ;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      r_state <= w_next_state;
    end
  end

  // Next-state logic. Flush takes priority over any handshake or response.
  always_comb begin
    // NOTE: defaulting first means no path leaves the value unassigned, so no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      S_REQ:     if (w_handshake)      w_next_state = S_WAIT;
      S_WAIT: begin
        if (icache_data_ok_i)          w_next_state = S_REQ;
        else if (flush)                w_next_state = S_DISCARD;
      end
      S_DISCARD: if (icache_data_ok_i) w_next_state = S_REQ;
      default:                         w_next_state = S_REQ;
    endcase
  end

  // Output logic. A request is issued only in REQ, and flush or a near-full buffer holds it off.
  always_comb begin
    w_req = 1'b0;
    if (r_state == S_REQ) w_req = ~flush & ~buffer_full_i;
  end

  assign icache_req_o  = w_req;
  assign icache_addr_o = {r_pc[31:2], 2'b00};

  // Datapath: the fetch PC, the PC of the outstanding request, and the registered push.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc         <= RESET_PC;
      r_req_pc     <= 32'd0;
      r_inst1      <= 32'd0;
      r_inst2      <= 32'd0;
      r_inst1_addr <= 32'd0;
      r_inst2_addr <= 32'd0;
      r_valid1     <= 1'b0;
      r_valid2     <= 1'b0;
    end else begin
      if (flush) begin
        r_pc <= {flush_pc[31:2], 2'b00};
      end else if (w_handshake) begin
        r_req_pc <= r_pc;
        // A PC with bit 2 set is the odd word of a pair, so only one word remains in its block.
        r_pc     <= r_pc + (r_pc[2] ? 32'd4 : 32'd8);
      end

      r_valid1 <= w_push;
      r_valid2 <= w_push & ~r_req_pc[2];
      if (w_push) begin
        r_inst1      <= icache_rdata1_i;
        r_inst2      <= icache_rdata2_i;
        r_inst1_addr <= r_req_pc;
        r_inst2_addr <= r_req_pc + 32'd4;
      end
    end
  end

  // A registered push is suppressed in the flush cycle so that it never lands after the redirect.
  assign inst1_o       = r_inst1;
  assign inst2_o       = r_inst2;
  assign inst1_addr_o  = r_inst1_addr;
  assign inst2_addr_o  = r_inst2_addr;
  assign inst1_valid_o = r_valid1 & ~flush;
  assign inst2_valid_o = r_valid2 & ~flush;

endmodule
